// File: rtl/phase_reader_if.sv
// Bus bundle for the phase-memory read unloader: the memory read port
// (rd_en/rd_addr/rd_data) plus the valid/ready output word stream.
// The master side is the reader itself; the slave side is the memory
// and downstream consumer (the testbench, or the host/output glue).
interface phase_reader_if #(
    parameter int AW = 5,
    parameter int DW = 16
) ();
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/phase_reader.sv
// Phase result memory unloader. On start it reads every word of the phase
// memory (addresses 0..WORDS-1), absorbs the memory's 1-cycle read latency,
// and presents the words on a valid/ready stream through a 2-entry FIFO.
// Reads are throttled so that words in the FIFO plus the read in flight
// never exceed the FIFO depth, so backpressure can never cause an overflow.
// rd_en is combinational from the state and FIFO fill so that a steady
// m_ready=1 stream sustains one word per cycle; m_valid/m_data/m_last are
// driven from registers holding the FIFO head.
module phase_reader #(
    parameter int N = 4,
    parameter int M = 16,
    parameter int L = 8,
    parameter int K = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           abort_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           aborted_o,
    phase_reader_if.master bus
);
    localparam int WORDS = (L * K) / N;
    localparam int AW    = $clog2(WORDS);
    localparam int EW    = $clog2(M);
    localparam int DW    = N * EW;
    localparam int CW    = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;

    logic [DW-1:0] buf_data_q [2];
    logic [DW-1:0] buf_data_d [2];
    logic          buf_last_q [2];
    logic          buf_last_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    occ_q, occ_d;

    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_last_q, m_last_d;

    logic          pop_s;
    logic          push_s;
    logic          flush_s;
    logic          rd_en_s;
    logic          last_issue_s;
    logic          drain_empty_s;
    logic [2:0]    outstanding_s;

    // Stream handshake, read throttle and drain-complete detection.
    always_comb begin
        pop_s         = m_valid_q & bus.m_ready;
        push_s        = infl_q & ~flush_s;
        last_issue_s  = (issue_cnt_q == LAST_CNT);
        // Words held after this edge's pop plus the read arriving next;
        // one more read may issue only while that stays below the depth.
        outstanding_s = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop_s};
        rd_en_s       = (state_q == ST_READ) & ~abort_i & (outstanding_s < 3'd2);
        drain_empty_s = ~infl_q & ({1'b0, pop_s} == occ_q);
    end

    // Control FSM: next state, read address/issue counter and status pulses.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        flush_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_READ;
                    issue_cnt_d = '0;
                    rd_addr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (abort_i) begin
                    state_d     = ST_IDLE;
                    issue_cnt_d = '0;
                    rd_addr_d   = '0;
                    aborted_d   = 1'b1;
                    flush_s     = 1'b1;
                end else if (rd_en_s) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (last_issue_s) begin
                        // Final address issued; hold it rather than wrap.
                        state_d   = ST_DRAIN;
                        rd_addr_d = rd_addr_q;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (abort_i) begin
                    state_d     = ST_IDLE;
                    issue_cnt_d = '0;
                    rd_addr_d   = '0;
                    aborted_d   = 1'b1;
                    flush_s     = 1'b1;
                end else if (drain_empty_s) begin
                    state_d     = ST_IDLE;
                    issue_cnt_d = '0;
                    rd_addr_d   = '0;
                    done_d      = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                issue_cnt_d = '0;
                rd_addr_d   = '0;
                flush_s     = 1'b1;
            end
        endcase
        busy_d      = (state_d != ST_IDLE);
        infl_d      = rd_en_s;
        infl_last_d = rd_en_s & last_issue_s;
    end

    // Two-entry FIFO update: capture returning read data, advance on pop.
    always_comb begin
        buf_data_d = buf_data_q;
        buf_last_d = buf_last_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        if (flush_s) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (push_s) begin
                buf_data_d[wr_ptr_q] = bus.rd_data;
                buf_last_d[wr_ptr_q] = infl_last_q;
                wr_ptr_d             = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            occ_d = occ_q + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Next FIFO head, loaded into the registered stream outputs.
    always_comb begin
        if (occ_d != 2'd0) begin
            m_valid_d = 1'b1;
            m_data_d  = buf_data_d[rd_ptr_d];
            m_last_d  = buf_last_d[rd_ptr_d];
        end else begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_last_d  = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            issue_cnt_q <= '0;
            rd_addr_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            rd_addr_q   <= rd_addr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q[0] <= 1'b0;
            buf_last_q[1] <= 1'b0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            occ_q         <= 2'd0;
        end else begin
            buf_data_q[0] <= buf_data_d[0];
            buf_data_q[1] <= buf_data_d[1];
            buf_last_q[0] <= buf_last_d[0];
            buf_last_q[1] <= buf_last_d[1];
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
        end
    end

    // Registered stream outputs mirroring the FIFO head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign bus.rd_en   = rd_en_s;
    assign bus.rd_addr = rd_addr_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
endmodule
